// File: rtl/muldiv_sequencer.sv
// Multicycle MIPS multiply/divide sequencer owning the architectural HI/LO registers.
// Radix-2 shift-add multiply / restoring divide on operand magnitudes, then a sign-fix cycle.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             HiWe,
    input  logic             LoWe,
    input  logic [WIDTH-1:0] WrData,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_sign_a;
    logic               r_sign_b;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_divzero;
    logic               r_busy;
    logic               r_done;

    // Op[1] selects divide, Op[0] selects the unsigned variant.
    logic w_is_div;
    logic w_signed_op;
    assign w_is_div    = r_op[1];
    assign w_signed_op = ~r_op[0];

    // Multiply step: add multiplicand into the 33-bit-extended upper half, then shift right.
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_b[0] ? {1'b0, r_a} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide step: dividend bits stream in from r_a's MSB; remainder always stays below the divisor.
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_trial;
    logic               w_div_ok;
    logic [WIDTH-1:0]   w_div_rem;
    logic [2*WIDTH-1:0] w_div_next;
    assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_a[WIDTH-1]};
    assign w_div_trial = w_div_shift - {1'b0, r_b};
    assign w_div_ok    = ~w_div_trial[WIDTH];
    assign w_div_rem   = w_div_ok ? w_div_trial[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
    assign w_div_next  = {w_div_rem, r_acc[WIDTH-2:0], w_div_ok};

    logic               w_neg_result;
    logic               w_neg_rem;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_quot_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    assign w_neg_result = w_signed_op & (r_sign_a ^ r_sign_b);
    assign w_neg_rem    = w_signed_op & r_sign_a;
    assign w_prod_fix   = w_neg_result ? -r_acc : r_acc;
    assign w_quot       = r_acc[WIDTH-1:0];
    assign w_rem        = r_acc[2*WIDTH-1:WIDTH];
    assign w_quot_fix   = w_neg_result ? -w_quot : w_quot;
    assign w_rem_fix    = w_neg_rem ? -w_rem : w_rem;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= S_IDLE;
            r_op      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_sign_a  <= 1'b0;
            r_sign_b  <= 1'b0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_divzero <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            // MTHI/MTLO; a result written later in this block takes precedence.
            if (!r_busy) begin
                if (HiWe) r_hi <= WrData;
                if (LoWe) r_lo <= WrData;
            end

            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (Start) begin
                        r_op     <= Op;
                        r_a      <= A;
                        r_b      <= B;
                        r_sign_a <= A[WIDTH-1];
                        r_sign_b <= B[WIDTH-1];
                        r_busy   <= 1'b1;
                        r_state  <= S_PREP;
                    end
                end
                S_PREP: begin
                    r_acc <= '0;
                    r_cnt <= CW'(WIDTH - 1);
                    if (w_is_div && (r_b == '0)) begin
                        r_hi      <= r_a;
                        r_lo      <= '1;
                        r_divzero <= 1'b1;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_divzero <= 1'b0;
                        // Most-negative value negates to itself, which reads correctly as unsigned 2^(W-1).
                        r_a       <= (w_signed_op && r_sign_a) ? -r_a : r_a;
                        r_b       <= (w_signed_op && r_sign_b) ? -r_b : r_b;
                        r_state   <= S_ITER;
                    end
                end
                S_ITER: begin
                    if (w_is_div) begin
                        r_acc <= w_div_next;
                        r_a   <= r_a << 1;
                    end else begin
                        r_acc <= w_mul_next;
                        r_b   <= r_b >> 1;
                    end
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) r_state <= S_FIX;
                end
                S_FIX: begin
                    if (w_is_div) begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quot_fix;
                    end else begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign Busy    = r_busy;
    assign Done    = r_done;
    assign DivZero = r_divzero;
    assign Hi      = r_hi;
    assign Lo      = r_lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed plus random ops against an arithmetic model.
module tb_muldiv_sequencer;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        HiWe;
    logic        LoWe;
    logic [31:0] WrData;
    logic        Busy;
    logic        Done;
    logic        DivZero;
    logic [31:0] Hi;
    logic [31:0] Lo;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
        .HiWe(HiWe), .LoWe(LoWe), .WrData(WrData),
        .Busy(Busy), .Done(Done), .DivZero(DivZero), .Hi(Hi), .Lo(Lo)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Architectural result of one MULT/MULTU/DIV/DIVU, from plain arithmetic.
    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo, output logic dz);
        logic [63:0] r;
        int sa, sb;
        dz = 1'b0;
        hi = '0;
        lo = '0;
        sa = a;
        sb = b;
        case (op)
            2'b00: begin
                r = longint'($signed(a)) * longint'($signed(b));
                hi = r[63:32];
                lo = r[31:0];
            end
            2'b01: begin
                r = {32'b0, a} * {32'b0, b};
                hi = r[63:32];
                lo = r[31:0];
            end
            default: begin
                if (b == 0) begin
                    hi = a;
                    lo = 32'hFFFFFFFF;
                    dz = 1'b1;
                end else if (op == 2'b11) begin
                    lo = a / b;
                    hi = a % b;
                end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                    lo = 32'h80000000;
                    hi = 32'h0;
                end else begin
                    lo = sa / sb;
                    hi = sa % sb;
                end
            end
        endcase
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eh, el;
        logic        edz;
        int cyc, busy_cnt, done_cyc, exp_done;
        model(op, a, b, eh, el, edz);
        exp_done = edz ? 2 : 35;
        Start = 1'b1; Op = op; A = a; B = b;
        step();
        Start = 1'b0;
        cyc = 1; busy_cnt = 0; done_cyc = 0;
        while (done_cyc == 0 && cyc < 100) begin
            if (Busy) busy_cnt++;
            if (Done) done_cyc = cyc;
            else begin
                step();
                cyc++;
            end
        end
        check("done_cycle", 64'(done_cyc), 64'(exp_done));
        check("busy_cycles", 64'(busy_cnt), 64'(exp_done - 1));
        check("hi", {32'b0, Hi}, {32'b0, eh});
        check("lo", {32'b0, Lo}, {32'b0, el});
        check("divzero", {63'b0, DivZero}, {63'b0, edz});
        $display("op=%0d a=%08h b=%08h -> hi=%08h lo=%08h dz=%0d done@%0d", op, a, b, Hi, Lo, DivZero, done_cyc);
        model_hi = eh;
        model_lo = el;
        step();
    endtask

    initial begin
        int dcnt, dfirst;
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        Reset = 1'b1; Start = 1'b0; Op = '0; A = '0; B = '0;
        HiWe = 1'b0; LoWe = 1'b0; WrData = '0;
        step();
        step();
        Reset = 1'b0;
        check("rst_busy", {63'b0, Busy}, 64'd0);
        check("rst_done", {63'b0, Done}, 64'd0);
        check("rst_divzero", {63'b0, DivZero}, 64'd0);
        check("rst_hi", {32'b0, Hi}, 64'd0);
        check("rst_lo", {32'b0, Lo}, 64'd0);
        step();

        run_op(2'b00, 32'hFFFFFFFD, 32'd7);
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_op(2'b00, 32'h80000000, 32'h80000000);
        run_op(2'b10, 32'hFFFFFFF9, 32'd2);
        run_op(2'b11, 32'd7, 32'd2);
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF);
        run_op(2'b11, 32'h00001234, 32'd0);
        run_op(2'b10, 32'd100, 32'hFFFFFFF9);
        run_op(2'b10, 32'h80000000, 32'd0);
        run_op(2'b00, 32'd5, 32'd3);

        // Start pulsed mid-operation must be ignored.
        Start = 1'b1; Op = 2'b01; A = 32'd5; B = 32'd6;
        step();
        Start = 1'b0;
        for (int i = 0; i < 9; i++) step();
        Start = 1'b1; Op = 2'b01; A = 32'd9; B = 32'd9;
        step();
        Start = 1'b0;
        dcnt = 0; dfirst = 0;
        for (int c = 11; c <= 80; c++) begin
            if (Done) begin
                dcnt++;
                if (dfirst == 0) dfirst = c;
            end
            step();
        end
        check("ignored_start_done_count", 64'(dcnt), 64'd1);
        check("ignored_start_done_cycle", 64'(dfirst), 64'd35);
        check("ignored_start_lo", {32'b0, Lo}, 64'd30);
        $display("ignored-start op: lo=%08h done_count=%0d", Lo, dcnt);

        // Reset mid-operation aborts and clears HI/LO.
        Start = 1'b1; Op = 2'b00; A = 32'd1000; B = 32'd1000;
        step();
        Start = 1'b0;
        for (int i = 0; i < 11; i++) step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check("abort_busy", {63'b0, Busy}, 64'd0);
        check("abort_hi", {32'b0, Hi}, 64'd0);
        check("abort_lo", {32'b0, Lo}, 64'd0);
        $display("reset mid-op: busy=%0d hi=%08h lo=%08h", Busy, Hi, Lo);
        run_op(2'b01, 32'h12345678, 32'h9ABCDEF0);

        // MTHI while idle.
        HiWe = 1'b1; WrData = 32'hCAFEBABE;
        step();
        HiWe = 1'b0;
        check("mthi", {32'b0, Hi}, 64'hCAFEBABE);
        $display("mthi: hi=%08h", Hi);
        model_hi = 32'hCAFEBABE;

        // MTLO while busy is ignored.
        Start = 1'b1; Op = 2'b01; A = 32'd3; B = 32'd4;
        step();
        Start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        LoWe = 1'b1; WrData = 32'h11111111;
        step();
        LoWe = 1'b0;
        check("mtlo_busy_ignored", {32'b0, Lo}, {32'b0, model_lo});
        dcnt = 0;
        for (int c = 0; c < 60 && dcnt == 0; c++) begin
            if (Done) dcnt = 1;
            else step();
        end
        check("mtlo_busy_done_seen", 64'(dcnt), 64'd1);
        check("mtlo_busy_result", {32'b0, Lo}, 64'd12);
        $display("mtlo while busy: lo=%08h", Lo);
        step();

        for (int t = 0; t < 24; t++) begin
            rop = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
            run_op(rop, ra, rb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
